// File: rtl/gray_rx_decoder.sv
// Gray-code receive decoder: synchronises a foreign-domain Gray count,
// decodes it to binary, classifies each change as a legal +/-1 step or
// an illegal multi-bit jump, and keeps a saturating error count.
module gray_rx_decoder #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ERR_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             clr_err,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic             step_valid,
   output logic             step_up,
   output logic             err_multi,
   output logic [ERR_W-1:0] err_count
);

   // Lock counter only has to reach SYNC_STAGES-1 (at most 3).
   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_LOCK = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // Registered state
   logic [WIDTH-1:0] r_sync [SYNC_STAGES];
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_gray_q;
   logic [WIDTH-1:0] r_bin_out;
   logic             r_bin_valid;
   logic             r_step_valid;
   logic             r_step_up;
   logic             r_err_multi;
   logic [ERR_W-1:0] r_err_count;

   // Next-state values
   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] w_gray_q_nxt;
   logic [WIDTH-1:0] w_bin_nxt;
   logic             w_valid_nxt;
   logic             w_step_nxt;
   logic             w_up_nxt;
   logic             w_err_nxt;
   logic [ERR_W-1:0] w_errcnt_nxt;

   // Datapath helpers
   logic [WIDTH-1:0] w_gray_s;
   logic [WIDTH-1:0] w_bin_s;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_delta;
   logic             w_changed;
   logic             w_single;

   // Full XOR prefix from the MSB down.
   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b = '0;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Synchroniser chain for the asynchronous Gray bus.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) begin
            r_sync[i] <= '0;
         end
      end else begin
         r_sync[0] <= gray_in;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   assign w_gray_s  = r_sync[SYNC_STAGES-1];
   assign w_bin_s   = gray2bin(w_gray_s);
   assign w_diff    = w_gray_s ^ r_gray_q;
   assign w_changed = (w_diff != '0);
   // A nonzero value with a single set bit clears to zero under x & (x-1).
   assign w_single  = w_changed && ((w_diff & (w_diff - WIDTH'(1))) == '0);
   // Modular difference new - old; exactly 1 means an upward step, wrap included.
   assign w_delta   = w_bin_s - r_bin_out;

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_INIT;
         r_cnt        <= '0;
         r_gray_q     <= '0;
         r_bin_out    <= '0;
         r_bin_valid  <= 1'b0;
         r_step_valid <= 1'b0;
         r_step_up    <= 1'b0;
         r_err_multi  <= 1'b0;
         r_err_count  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_gray_q     <= w_gray_q_nxt;
         r_bin_out    <= w_bin_nxt;
         r_bin_valid  <= w_valid_nxt;
         r_step_valid <= w_step_nxt;
         r_step_up    <= w_up_nxt;
         r_err_multi  <= w_err_nxt;
         r_err_count  <= w_errcnt_nxt;
      end
   end

   // Next-state and output decode: INIT waits out the synchroniser, LOCK
   // captures the first sample, RUN classifies every change.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_gray_q_nxt = r_gray_q;
      w_bin_nxt    = r_bin_out;
      w_valid_nxt  = r_bin_valid;
      w_step_nxt   = 1'b0;
      w_up_nxt     = r_step_up;
      w_err_nxt    = 1'b0;

      case (r_state)
         ST_INIT: begin
            if (r_cnt == CNT_W'(SYNC_STAGES - 1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_LOCK;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_LOCK: begin
            w_gray_q_nxt = w_gray_s;
            w_bin_nxt    = w_bin_s;
            w_valid_nxt  = 1'b1;
            w_state_nxt  = ST_RUN;
         end
         ST_RUN: begin
            if (w_changed) begin
               w_gray_q_nxt = w_gray_s;
               w_bin_nxt    = w_bin_s;
               if (w_single) begin
                  w_step_nxt = 1'b1;
                  w_up_nxt   = (w_delta == WIDTH'(1));
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
            w_cnt_nxt   = '0;
         end
      endcase

      // Clear takes effect first, so an error in the same cycle counts as 1.
      w_errcnt_nxt = r_err_count;
      if (clr_err) begin
         w_errcnt_nxt = w_err_nxt ? ERR_W'(1) : '0;
      end else if (w_err_nxt && (r_err_count != '1)) begin
         w_errcnt_nxt = r_err_count + ERR_W'(1);
      end
   end

   assign bin_out    = r_bin_out;
   assign bin_valid  = r_bin_valid;
   assign step_valid = r_step_valid;
   assign step_up    = r_step_up;
   assign err_multi  = r_err_multi;
   assign err_count  = r_err_count;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Directed bench for gray_rx_decoder (WIDTH=8, SYNC_STAGES=2, ERR_W=8).
module tb_gray_rx_decoder;

   logic       clk;
   logic       reset;
   logic [7:0] gray_in;
   logic       clr_err;
   logic [7:0] bin_out;
   logic       bin_valid;
   logic       step_valid;
   logic       step_up;
   logic       err_multi;
   logic [7:0] err_count;

   int n_vec;
   int n_err;

   gray_rx_decoder #(
      .WIDTH      (8),
      .SYNC_STAGES(2),
      .ERR_W      (8)
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .gray_in   (gray_in),
      .clr_err   (clr_err),
      .bin_out   (bin_out),
      .bin_valid (bin_valid),
      .step_valid(step_valid),
      .step_up   (step_up),
      .err_multi (err_multi),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then step off it before sampling/driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input logic [7:0] g);
      gray_in = g;
      repeat (6) tick();
   endtask

   // New value reaches bin_out on the third edge after it is driven.
   task automatic apply(input logic [7:0] g);
      gray_in = g;
      repeat (3) tick();
   endtask

   task automatic clear_errs();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      reset   = 1'b0;
      gray_in = 8'h00;
      clr_err = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_bin_out",   32'(bin_out),    32'h00);
      check("rst_bin_valid", 32'(bin_valid),  32'h0);
      check("rst_step",      32'(step_valid), 32'h0);
      check("rst_err_multi", 32'(err_multi),  32'h0);
      check("rst_err_count", 32'(err_count),  32'h00);

      // Test 1: lock then +1 step with exact latency
      reset = 1'b1;
      repeat (2) tick();
      check("t1_valid_early", 32'(bin_valid), 32'h0);
      tick();
      check("t1_valid_lock",  32'(bin_valid), 32'h1);
      check("t1_lock_step",   32'(step_valid), 32'h0);
      repeat (3) tick();
      gray_in = 8'h01;
      repeat (2) tick();
      check("t1_bin_before",  32'(bin_out),    32'h00);
      check("t1_step_before", 32'(step_valid), 32'h0);
      tick();
      check("t1_bin",         32'(bin_out),    32'h01);
      check("t1_step",        32'(step_valid), 32'h1);
      check("t1_up",          32'(step_up),    32'h1);
      tick();
      check("t1_step_pulse",  32'(step_valid), 32'h0);

      // Test 2: wrap 0xFF -> 0x00 counts as up
      settle(8'h80);
      check("t2_settle_bin", 32'(bin_out), 32'hFF);
      clear_errs();
      check("t2_clr", 32'(err_count), 32'h00);
      apply(8'h00);
      check("t2_bin",  32'(bin_out),    32'h00);
      check("t2_step", 32'(step_valid), 32'h1);
      check("t2_up",   32'(step_up),    32'h1);
      check("t2_err",  32'(err_multi),  32'h0);

      // Test 3: down step 3 -> 2
      settle(8'h02);
      check("t3_settle_bin", 32'(bin_out), 32'h03);
      apply(8'h03);
      check("t3_bin",  32'(bin_out),    32'h02);
      check("t3_step", 32'(step_valid), 32'h1);
      check("t3_up",   32'(step_up),    32'h0);

      // Test 4: illegal two-bit jump
      settle(8'h00);
      clear_errs();
      apply(8'h03);
      check("t4_err",      32'(err_multi),  32'h1);
      check("t4_errcnt",   32'(err_count),  32'h01);
      check("t4_bin",      32'(bin_out),    32'h02);
      check("t4_step",     32'(step_valid), 32'h0);
      check("t4_up_hold",  32'(step_up),    32'h0);
      tick();
      check("t4_err_pulse", 32'(err_multi), 32'h0);

      // Test 5: saturate, then clear coincident with an error, then clear alone
      for (int i = 0; i < 300; i++) begin
         gray_in = (i % 2 == 0) ? 8'h00 : 8'h03;
         tick();
      end
      repeat (4) tick();
      check("t5_saturated", 32'(err_count), 32'hFF);
      gray_in = 8'h00;
      repeat (2) tick();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("t5_coinc_err",   32'(err_multi), 32'h1);
      check("t5_coinc_count", 32'(err_count), 32'h01);
      clear_errs();
      check("t5_clr_alone",   32'(err_count), 32'h00);

      // Test 6: asynchronous reset mid-run, then relock without a step
      settle(8'h77);
      check("t6_bin_5a", 32'(bin_out), 32'h5A);
      #2;
      reset = 1'b0;
      #1;
      check("t6_async_bin",   32'(bin_out),   32'h00);
      check("t6_async_valid", 32'(bin_valid), 32'h0);
      check("t6_async_cnt",   32'(err_count), 32'h00);
      check("t6_async_up",    32'(step_up),   32'h0);
      tick();
      reset = 1'b1;
      repeat (2) tick();
      check("t6_valid_early", 32'(bin_valid), 32'h0);
      tick();
      check("t6_valid", 32'(bin_valid), 32'h1);
      check("t6_relock_bin", 32'(bin_out), 32'h5A);
      for (int i = 0; i < 4; i++) begin
         check("t6_no_step", 32'(step_valid), 32'h0);
         check("t6_no_err",  32'(err_multi),  32'h0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
